avg_sched: RTL and testbench



---
 rtl/avg_sched_pkg.sv | 16 +
 rtl/avg_sched_tick_gen.sv | 28 ++
 rtl/avg_sched.sv | 148 ++++++++++++++
 tb/tb_avg_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/avg_sched_pkg.sv
// Shared types and defaults for the SMA/EMA sample scheduler.
// Optional timeout path is enabled by AVG_SCHED_TIMEOUT_EN.
package avg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    REPORT
  } state_t;

  localparam int TICK_COUNT_DEF = 50_000_000;
  localparam int TIMEOUT_DEF    = 255;
  localparam int OVR_W          = 8;

endpackage

// File: rtl/avg_sched_tick_gen.sv
// Free-running timebase: one-cycle registered tick per period.
// Counter width follows TICK_COUNT.
module tick_gen
  import avg_sched_pkg::*;
#(
  parameter int TICK_COUNT = TICK_COUNT_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = $clog2(TICK_COUNT);
  localparam logic [W-1:0] LAST = W'(TICK_COUNT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/avg_sched.sv
// Sample scheduler launching SMA/EMA cores per tick and merging results.
// Define AVG_SCHED_TIMEOUT_EN to enable the WAIT timeout/abort path.
module avg_sched
  import avg_sched_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TICK_COUNT = TICK_COUNT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] sample_in,
  output logic              sma_start,
  output logic              ema_start,
  output logic [DATA_W-1:0] sma_din,
  output logic [DATA_W-1:0] ema_din,
  input  logic              sma_done,
  input  logic              ema_done,
  input  logic [DATA_W-1:0] sma_result,
  input  logic [DATA_W-1:0] ema_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_sma,
  output logic [DATA_W-1:0] res_ema,
  output logic [DATA_W:0]   res_diff,
  output logic              busy,
  output logic [OVR_W-1:0]  overrun_cnt,
  output logic              err_timeout
);

  state_t state;
  logic   tick;

  logic              sma_f;
  logic              ema_f;
  logic [DATA_W-1:0] sma_lat;
  logic [DATA_W-1:0] ema_lat;

  logic              sma_hit;
  logic              ema_hit;
  logic              both;
  logic [DATA_W-1:0] sma_v;
  logic [DATA_W-1:0] ema_v;
  logic [DATA_W:0]   diff_n;

  tick_gen #(
    .TICK_COUNT(TICK_COUNT)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Only the first done per core in WAIT counts.
  assign sma_hit = (state == WAIT) && sma_done && !sma_f;
  assign ema_hit = (state == WAIT) && ema_done && !ema_f;
  assign sma_v   = sma_hit ? sma_result : sma_lat;
  assign ema_v   = ema_hit ? ema_result : ema_lat;
  assign both    = (sma_f || sma_hit) && (ema_f || ema_hit);
  assign diff_n  = {1'b0, sma_v} - {1'b0, ema_v};
  assign busy    = (state != IDLE);

`ifdef AVG_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tocnt;
`else
  logic unused_cfg;
  assign unused_cfg  = (TIMEOUT > 0);
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sma_start   <= 1'b0;
      ema_start   <= 1'b0;
      sma_din     <= '0;
      ema_din     <= '0;
      res_valid   <= 1'b0;
      res_sma     <= '0;
      res_ema     <= '0;
      res_diff    <= '0;
      overrun_cnt <= '0;
      sma_f       <= 1'b0;
      ema_f       <= 1'b0;
      sma_lat     <= '0;
      ema_lat     <= '0;
`ifdef AVG_SCHED_TIMEOUT_EN
      tocnt       <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      sma_start <= 1'b0;
      ema_start <= 1'b0;
      res_valid <= 1'b0;
      if (tick && state != IDLE && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (tick && en) begin
            sma_din   <= sample_in;
            ema_din   <= sample_in;
            sma_start <= 1'b1;
            ema_start <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          sma_f <= 1'b0;
          ema_f <= 1'b0;
`ifdef AVG_SCHED_TIMEOUT_EN
          tocnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (sma_hit) begin
            sma_f   <= 1'b1;
            sma_lat <= sma_result;
          end
          if (ema_hit) begin
            ema_f   <= 1'b1;
            ema_lat <= ema_result;
          end
          if (both) begin
            res_valid <= 1'b1;
            res_sma   <= sma_v;
            res_ema   <= ema_v;
            res_diff  <= diff_n;
            state     <= REPORT;
          end
`ifdef AVG_SCHED_TIMEOUT_EN
          else if (tocnt == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tocnt <= tocnt + 1'b1;
          end
`endif
        end
        REPORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_sched.sv
// Randomized bench for avg_sched against a timing/arithmetic reference model.
// Adapts expectations to AVG_SCHED_TIMEOUT_EN.
module tb_avg_sched;

  localparam int DW    = 8;
  localparam int TC    = 8;
  localparam int TO    = 12;
  localparam int NEVER = -1000;
`ifdef AVG_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    int smp;
    int ds;
    int de;
    int rs;
    int re;
  } op_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sma_start, ema_start;
  logic [DW-1:0] sma_din, ema_din;
  logic          sma_done = 1'b0, ema_done = 1'b0;
  logic [DW-1:0] sma_result = '0, ema_result = '0;
  logic          res_valid;
  logic [DW-1:0] res_sma, res_ema;
  logic [DW:0]   res_diff;
  logic          busy;
  logic [7:0]    overrun_cnt;
  logic          err_timeout;

  always #5 clk = ~clk;

  avg_sched #(
    .DATA_W(DW),
    .TICK_COUNT(TC),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .sample_in(sample_in),
    .sma_start(sma_start), .ema_start(ema_start),
    .sma_din(sma_din), .ema_din(ema_din),
    .sma_done(sma_done), .ema_done(ema_done),
    .sma_result(sma_result), .ema_result(ema_result),
    .res_valid(res_valid),
    .res_sma(res_sma), .res_ema(res_ema),
    .res_diff(res_diff),
    .busy(busy),
    .overrun_cnt(overrun_cnt),
    .err_timeout(err_timeout)
  );

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_ok++;
    else $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h",
                  tag, cyc, got, exp);
  endtask

  // Reference model: event cycles of the current operation.
  int cyc;
  int launch_c, w_c, sd_c, ed_c, rv_c, idle_c;
  bit abort, dup_s, dup_e, noise;
  logic [7:0] p_din, p_rs, p_re;
  logic [7:0] x_din, x_rs, x_re;
  logic [8:0] x_rd;
  bit   x_err;
  int   x_ovr;
  int   late;
  op_t  dq[$];

  task automatic model_reset();
    cyc = 0;
    launch_c = NEVER; w_c = NEVER; sd_c = NEVER; ed_c = NEVER;
    rv_c = NEVER; idle_c = NEVER;
    abort = 0; dup_s = 0; dup_e = 0; noise = 0;
    p_din = 0; p_rs = 0; p_re = 0;
    x_din = 0; x_rs = 0; x_re = 0; x_rd = 0; x_err = 0; x_ovr = 0;
  endtask

  task automatic chk_reset();
    chk("rst_sma_start", sma_start, 0);
    chk("rst_ema_start", ema_start, 0);
    chk("rst_sma_din", sma_din, 0);
    chk("rst_ema_din", ema_din, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sma", res_sma, 0);
    chk("rst_res_ema", res_ema, 0);
    chk("rst_res_diff", res_diff, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun_cnt, 0);
    chk("rst_err", err_timeout, 0);
  endtask

  function automatic int pick();
    if (TO_EN && $urandom_range(9) == 0) return -1;
    if ($urandom_range(1) == 1) return int'($urandom_range(11, 5));
    return int'($urandom_range(11, 0));
  endfunction

  task automatic launch(input int t);
    op_t o;
    int  mx;
    if (dq.size() > 0) begin
      o = dq.pop_front();
      if (o.smp >= 0) sample_in = 8'(o.smp);
    end else begin
      o.smp = -1;
      o.ds = pick();
      o.de = pick();
      o.rs = int'($urandom_range(255));
      o.re = int'($urandom_range(255));
    end
    p_din = sample_in;
    p_rs = 8'(o.rs);
    p_re = 8'(o.re);
    launch_c = t + 1;
    w_c = t + 2;
    sd_c = (o.ds < 0) ? NEVER : w_c + o.ds;
    ed_c = (o.de < 0) ? NEVER : w_c + o.de;
    mx = (o.ds > o.de) ? o.ds : o.de;
    if (o.ds >= 0 && o.de >= 0 && (!TO_EN || mx < TO)) begin
      rv_c = w_c + mx + 1;
      idle_c = rv_c + 1;
      abort = 0;
    end else begin
      rv_c = NEVER;
      abort = TO_EN;
      idle_c = TO_EN ? w_c + TO : (1 << 30);
    end
    dup_s = 1'($urandom_range(1));
    dup_e = 1'($urandom_range(1));
    noise = 1'($urandom_range(1));
  endtask

  task automatic run_cycle(input bit rnd, input bit do_rst);
    bit tk, bz;
    if (cyc == launch_c) x_din = p_din;
    if (cyc == rv_c) begin
      x_rs = p_rs;
      x_re = p_re;
      x_rd = 9'(int'(p_rs) - int'(p_re));
    end
    if (abort && cyc == idle_c) x_err = 1'b1;
    bz = (cyc >= launch_c) && (cyc < idle_c);
    chk("sma_start", sma_start, int'(cyc == launch_c));
    chk("ema_start", ema_start, int'(cyc == launch_c));
    chk("sma_din", sma_din, x_din);
    chk("ema_din", ema_din, x_din);
    chk("res_valid", res_valid, int'(cyc == rv_c));
    chk("res_sma", res_sma, x_rs);
    chk("res_ema", res_ema, x_re);
    chk("res_diff", res_diff, x_rd);
    chk("busy", busy, int'(bz));
    chk("overrun", overrun_cnt, x_ovr);
    chk("err_timeout", err_timeout, int'(x_err));
    tk = (cyc > 0) && (cyc % TC == 0);
    en = rnd ? ($urandom_range(3) != 0) : 1'b1;
    sample_in = 8'($urandom);
    if (tk && bz && x_ovr < 255) x_ovr++;
    if (tk && !bz && en) launch(cyc);
    sma_done = (cyc == sd_c) || (dup_s && cyc == sd_c + 1) ||
               (noise && cyc == launch_c) || (late > 0);
    ema_done = (cyc == ed_c) || (dup_e && cyc == ed_c + 1) ||
               (noise && cyc == launch_c) || (late > 0);
    sma_result = (cyc == sd_c) ? p_rs : 8'($urandom);
    ema_result = (cyc == ed_c) ? p_re : 8'($urandom);
    if (late > 0) late--;
    if (do_rst) rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (do_rst) begin
      chk_reset();
      model_reset();
      rst = 1'b0;
      late = 3;
    end
  endtask

  initial begin
    int post;
    model_reset();
    late = 0;
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    cyc = 0;

    dq.push_back('{32'h40, 1, 1, 32'h30, 32'h28});
    dq.push_back('{-1, 0, 2, 32'h10, 32'h20});
    if (TO_EN) dq.push_back('{-1, 1, -1, 32'h55, 32'h00});
    dq.push_back('{-1, 0, TO - 1, 32'h7F, 32'hFF});
    dq.push_back('{-1, TO - 1, TO - 1, 32'hFF, 32'h00});
    for (int i = 0; i < 400 && (dq.size() > 0 || cyc < idle_c + 2); i++)
      run_cycle(1'b0, 1'b0);

    post = 0;
    for (int i = 0; i < 20000 && post < 400; i++) begin
      run_cycle(1'b1, 1'b0);
      if (x_ovr == 255) post++;
    end
    chk("ovr_saturated", overrun_cnt, 255);

    dq.push_back('{32'hA5, -1, -1, 32'h11, 32'h22});
    for (int i = 0; i < 64 && dq.size() > 0; i++)
      run_cycle(1'b0, 1'b0);
    for (int i = 0; i < 64 && cyc < w_c + (TO_EN ? 1 : 20); i++)
      run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      run_cycle(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
